// File: rtl/soc_ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_ctrl_seq_pkg
//  Description : Shared types and helpers for the power-domain clock/reset
//                sequencer: FSM state encoding, latched command record and
//                find-first / find-last selection functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_ctrl_seq_pkg;

    // Widest domain vector the sequencer supports; narrower configurations
    // zero-extend into these types.
    localparam int unsigned MAX_DOM   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CLK_ON   = 4'd1,
        CLK_WAIT = 4'd2,
        RST_REL  = 4'd3,
        RST_WAIT = 4'd4,
        RST_ASRT = 4'd5,
        RST_HOLD = 4'd6,
        CLK_OFF  = 4'd7,
        CLK_HOLD = 4'd8,
        DONE     = 4'd9
    } seq_state_e;

    // Direction and remaining-domain mask of the command being executed.
    typedef struct packed {
        logic               on;
        logic [MAX_DOM-1:0] mask;
    } seq_cmd_t;

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [MAX_IDX_W-1:0] find_first(input logic [MAX_DOM-1:0] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_DOM - 1; i >= 0; i--) begin
            if (v[i]) idx = MAX_IDX_W'(i);
        end
        return idx;
    endfunction

    // Index of the highest set bit (0 when the vector is empty).
    function automatic logic [MAX_IDX_W-1:0] find_last(input logic [MAX_DOM-1:0] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_DOM; i++) begin
            if (v[i]) idx = MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soc_ctrl_seq_wait_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : soc_ctrl_seq_wait_cnt
//  Description : Loadable saturating down counter used for every settle gap
//                of the sequencer. zero_o flags the end of the gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_ctrl_seq_wait_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load on request, otherwise count down and hold at zero.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/soc_ctrl_clk_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : soc_ctrl_clk_rst_seq
//  Description : Power-domain bring-up / shut-down sequencer. Raises clock
//                enable then releases reset per domain in ascending order on
//                power-up; asserts reset then gates the clock in descending
//                order on power-down, with programmable settle gaps.
//  Options     : SOC_CTRL_SEQ_STATUS_EN adds cur_dom_o / state_o debug ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_ctrl_clk_rst_seq
    import soc_ctrl_seq_pkg::*;
#(
    parameter int unsigned NUM_DOM    = 4,
    parameter int unsigned CLK_SETTLE = 4,
    parameter int unsigned RST_SETTLE = 8
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_on_i,
    input  logic [NUM_DOM-1:0] cmd_mask_i,
    output logic [NUM_DOM-1:0] clk_en_o,
    output logic [NUM_DOM-1:0] arst_no,
    output logic [NUM_DOM-1:0] dom_on_o,
    output logic               busy_o,
    output logic               done_o
`ifdef SOC_CTRL_SEQ_STATUS_EN
    ,
    output logic [((NUM_DOM > 1) ? $clog2(NUM_DOM) : 1)-1:0] cur_dom_o,
    output logic [3:0]                                        state_o
`endif
);

    localparam int unsigned IDX_W      = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam int unsigned MAX_SETTLE = (CLK_SETTLE > RST_SETTLE) ? CLK_SETTLE : RST_SETTLE;
    localparam int unsigned CNT_W      = $clog2(MAX_SETTLE + 1);
    localparam logic [CNT_W-1:0] CLK_LOAD = CNT_W'(CLK_SETTLE - 1);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_SETTLE - 1);

    seq_state_e         state_q, state_d;
    seq_cmd_t           cmd_q, cmd_d;
    logic [NUM_DOM-1:0] clk_en_q, clk_en_d;
    logic [NUM_DOM-1:0] rel_q, rel_d;       // reset released (active-high view)
    logic [NUM_DOM-1:0] dom_on_q, dom_on_d;

    logic [NUM_DOM-1:0] w_acc_eff;
    logic [IDX_W-1:0]   w_acc_sel;
    logic [IDX_W-1:0]   w_cur_sel;
    logic               w_cnt_zero;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               go;
    logic               go_on;
    logic [IDX_W-1:0]   go_sel;

    // Effective mask skips domains already in the requested state.
    assign w_acc_eff = cmd_on_i ? (cmd_mask_i & ~dom_on_q) : (cmd_mask_i & dom_on_q);
    assign w_acc_sel = cmd_on_i ? IDX_W'(find_first(MAX_DOM'(w_acc_eff)))
                                : IDX_W'(find_last(MAX_DOM'(w_acc_eff)));
    // Domain in progress: the remaining mask only loses its bit when the
    // domain finishes, so this stays stable for the whole domain.
    assign w_cur_sel = cmd_q.on ? IDX_W'(find_first(cmd_q.mask))
                                : IDX_W'(find_last(cmd_q.mask));

    soc_ctrl_seq_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (w_cnt_zero)
    );

    // State and output registers; reset drops every domain at once.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            clk_en_q <= '0;
            rel_q    <= '0;
            dom_on_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            clk_en_q <= clk_en_d;
            rel_q    <= rel_d;
            dom_on_q <= dom_on_d;
        end
    end

    // Next-state: each output edge is taken on the transition that ends the
    // preceding gap, so outputs come straight from registers.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        clk_en_d = clk_en_q;
        rel_d    = rel_q;
        dom_on_d = dom_on_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        go       = 1'b0;
        go_on    = cmd_q.on;
        go_sel   = w_cur_sel;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    cmd_d.on   = cmd_on_i;
                    cmd_d.mask = MAX_DOM'(w_acc_eff);
                    if (w_acc_eff == '0) begin
                        state_d = DONE;
                    end else begin
                        go     = 1'b1;
                        go_on  = cmd_on_i;
                        go_sel = w_acc_sel;
                    end
                end
            end
            // Dispatch cycle between domains.
            CLK_ON, RST_ASRT: begin
                if (cmd_q.mask == '0) begin
                    state_d = DONE;
                end else begin
                    go = 1'b1;
                end
            end
            CLK_WAIT: begin
                if (w_cnt_zero) begin
                    rel_d[w_cur_sel] = 1'b1;
                    cnt_load         = 1'b1;
                    cnt_val          = RST_LOAD;
                    state_d          = RST_REL;
                end
            end
            RST_REL, RST_WAIT: begin
                if (w_cnt_zero) begin
                    dom_on_d[w_cur_sel] = 1'b1;
                    cmd_d.mask          = cmd_q.mask & ~(MAX_DOM'(1) << w_cur_sel);
                    state_d             = CLK_ON;
                end else begin
                    state_d = RST_WAIT;
                end
            end
            RST_HOLD: begin
                if (w_cnt_zero) begin
                    clk_en_d[w_cur_sel] = 1'b0;
                    cnt_load            = 1'b1;
                    cnt_val             = CLK_LOAD;
                    state_d             = CLK_OFF;
                end
            end
            CLK_OFF, CLK_HOLD: begin
                if (w_cnt_zero) begin
                    dom_on_d[w_cur_sel] = 1'b0;
                    cmd_d.mask          = cmd_q.mask & ~(MAX_DOM'(1) << w_cur_sel);
                    state_d             = RST_ASRT;
                end else begin
                    state_d = CLK_HOLD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Launch a domain: clock first on power-up, reset first on power-down.
        if (go) begin
            cnt_load = 1'b1;
            if (go_on) begin
                clk_en_d[go_sel] = 1'b1;
                cnt_val          = CLK_LOAD;
                state_d          = CLK_WAIT;
            end else begin
                rel_d[go_sel] = 1'b0;
                cnt_val       = RST_LOAD;
                state_d       = RST_HOLD;
            end
        end
    end

    assign clk_en_o    = clk_en_q;
    assign arst_no     = rel_q;
    assign dom_on_o    = dom_on_q;
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

`ifdef SOC_CTRL_SEQ_STATUS_EN
    assign cur_dom_o = (state_q == IDLE) ? '0 : w_cur_sel;
    assign state_o   = state_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_soc_ctrl_clk_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_ctrl_clk_rst_seq
//  Description : Self-checking bench for soc_ctrl_clk_rst_seq. Expected
//                outputs come from an event-time model of the sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_ctrl_clk_rst_seq;

    localparam int ND = 4;
    localparam int C  = 4;
    localparam int R  = 8;
    localparam int P  = C + R + 1;   // cycles spent per sequenced domain

    logic          clk;
    logic          arst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_on;
    logic [ND-1:0] cmd_mask;
    logic [ND-1:0] clk_en_o;
    logic [ND-1:0] arst_no;
    logic [ND-1:0] dom_on_o;
    logic          busy_o;
    logic          done_o;
`ifdef SOC_CTRL_SEQ_STATUS_EN
    logic [1:0]    cur_dom_o;
    logic [3:0]    state_o;
`endif

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [ND-1:0] model_on;

    soc_ctrl_clk_rst_seq #(
        .NUM_DOM    (ND),
        .CLK_SETTLE (C),
        .RST_SETTLE (R)
    ) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_on_i    (cmd_on),
        .cmd_mask_i  (cmd_mask),
        .clk_en_o    (clk_en_o),
        .arst_no     (arst_no),
        .dom_on_o    (dom_on_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef SOC_CTRL_SEQ_STATUS_EN
        ,
        .cur_dom_o   (cur_dom_o),
        .state_o     (state_o)
`endif
    );

    always #5 clk = ~clk;

    // A released reset must never coexist with a gated clock.
    assert property (@(posedge clk) disable iff (arst) ((arst_no & ~clk_en_o) == '0))
        else begin
            n_fail++;
            $display("FAIL invariant: arst_no=%b clk_en=%b", arst_no, clk_en_o);
        end

    // Effective mask of a command given the current domain state.
    function automatic logic [ND-1:0] eff_of(input logic [ND-1:0] pre, input logic on,
                                             input logic [ND-1:0] mask);
        return on ? (mask & ~pre) : (mask & pre);
    endfunction

    // Cycle (after accept) at which done_o is expected.
    function automatic int done_cycle(input logic [ND-1:0] eff);
        int n;
        n = $countones(eff);
        return (n == 0) ? 1 : 1 + n * P;
    endfunction

    // Expected {clk_en, arst_n, dom_on, busy, done, ready} k cycles after
    // accept: domain at order position p starts at 1 + p*P.
    function automatic logic [3*ND+2:0] model(input logic [ND-1:0] pre, input logic on,
                                              input logic [ND-1:0] eff, input int k);
        logic [ND-1:0] ce, an, dn;
        int pos, s, t;
        ce = pre; an = pre; dn = pre;
        for (int d = 0; d < ND; d++) begin
            if (eff[d]) begin
                pos = 0;
                for (int j = 0; j < ND; j++) begin
                    if (eff[j] && (on ? (j < d) : (j > d))) pos++;
                end
                s = 1 + pos * P;
                if (on) begin
                    ce[d] = (k >= s);
                    an[d] = (k >= s + C);
                    dn[d] = (k >= s + C + R);
                end else begin
                    an[d] = (k < s);
                    ce[d] = (k < s + R);
                    dn[d] = (k < s + R + C);
                end
            end
        end
        t = done_cycle(eff);
        return {ce, an, dn, (k <= t), (k == t), (k > t)};
    endfunction

    task automatic test_reset();
        logic [3*ND+2:0] got;
        got = {clk_en_o, arst_no, dom_on_o, busy_o, done_o, cmd_ready};
        n_chk++;
        if (got[3*ND+2:1] !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got=%b exp=%b", got[3*ND+2:1], {(3*ND+2){1'b0}});
        end
        arst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            got = {clk_en_o, arst_no, dom_on_o, busy_o, done_o, cmd_ready};
            n_chk++;
            if (got !== {{(3*ND+2){1'b0}}, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_idle k=%0d: got=%b exp=%b", k, got, {{(3*ND+2){1'b0}}, 1'b1});
            end
        end
        model_on = '0;
    endtask

    task automatic test_power_up();
        logic [3*ND+2:0] got, exp;
        logic [ND-1:0] eff;
        int t;
        cmd_on = 1'b1; cmd_mask = 4'b0101; cmd_valid = 1'b1;
        eff = eff_of(model_on, 1'b1, 4'b0101);
        t = done_cycle(eff);
        for (int k = 1; k <= t + 1; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            exp = model(model_on, 1'b1, eff, k);
            got = {clk_en_o, arst_no, dom_on_o, busy_o, done_o, cmd_ready};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL power_up k=%0d: got=%b exp=%b", k, got, exp);
            end
        end
        model_on = model_on | eff;
    endtask

    task automatic test_power_down();
        logic [3*ND+2:0] got, exp;
        logic [ND-1:0] eff;
        int t;
        cmd_on = 1'b0; cmd_mask = 4'b1111; cmd_valid = 1'b1;
        eff = eff_of(model_on, 1'b0, 4'b1111);
        t = done_cycle(eff);
        for (int k = 1; k <= t + 1; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            exp = model(model_on, 1'b0, eff, k);
            got = {clk_en_o, arst_no, dom_on_o, busy_o, done_o, cmd_ready};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL power_down k=%0d: got=%b exp=%b", k, got, exp);
            end
        end
        model_on = model_on & ~eff;
    endtask

    // Bring domain 0 up, then repeat the same command: nothing left to do.
    task automatic test_noop();
        logic [3*ND+2:0] got, exp;
        logic [ND-1:0] eff;
        int t;
        for (int rep = 0; rep < 2; rep++) begin
            cmd_on = 1'b1; cmd_mask = 4'b0001; cmd_valid = 1'b1;
            eff = eff_of(model_on, 1'b1, 4'b0001);
            t = done_cycle(eff);
            for (int k = 1; k <= t + 1; k++) begin
                @(negedge clk);
                if (k == 1) cmd_valid = 1'b0;
                exp = model(model_on, 1'b1, eff, k);
                got = {clk_en_o, arst_no, dom_on_o, busy_o, done_o, cmd_ready};
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL noop rep=%0d k=%0d: got=%b exp=%b", rep, k, got, exp);
                end
            end
            model_on = model_on | eff;
        end
    endtask

    task automatic test_async_reset();
        logic [3*ND+2:0] got, exp;
        logic [ND-1:0] eff;
        int t;
        // Start from everything off.
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        model_on = '0;
        @(negedge clk);
        cmd_on = 1'b1; cmd_mask = 4'b0101; cmd_valid = 1'b1;
        eff = eff_of(model_on, 1'b1, 4'b0101);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            exp = model(model_on, 1'b1, eff, k);
            got = {clk_en_o, arst_no, dom_on_o, busy_o, done_o, cmd_ready};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL arst_pre k=%0d: got=%b exp=%b", k, got, exp);
            end
        end
        arst = 1'b1;
        #1;
        got = {clk_en_o, arst_no, dom_on_o, busy_o, done_o, cmd_ready};
        n_chk++;
        if (got[3*ND+2:1] !== '0) begin
            n_fail++;
            $display("FAIL arst_drop: got=%b exp=%b", got[3*ND+2:1], {(3*ND+2){1'b0}});
        end
        @(negedge clk);
        arst = 1'b0;
        model_on = '0;
        @(negedge clk);
        cmd_on = 1'b1; cmd_mask = 4'b0001; cmd_valid = 1'b1;
        eff = eff_of(model_on, 1'b1, 4'b0001);
        t = done_cycle(eff);
        for (int k = 1; k <= t + 1; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            exp = model(model_on, 1'b1, eff, k);
            got = {clk_en_o, arst_no, dom_on_o, busy_o, done_o, cmd_ready};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL arst_post k=%0d: got=%b exp=%b", k, got, exp);
            end
        end
        model_on = model_on | eff;
    endtask

    // Valid stays high with a new command while busy; it must be taken
    // exactly when ready returns.
    task automatic test_back_to_back();
        logic [3*ND+2:0] got, exp;
        logic [ND-1:0] eff_a, eff_b;
        int ta, tb;
        cmd_on = 1'b1; cmd_mask = 4'b1110; cmd_valid = 1'b1;
        eff_a = eff_of(model_on, 1'b1, 4'b1110);
        ta = done_cycle(eff_a);
        for (int k = 1; k <= ta + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_on = 1'b0; cmd_mask = 4'b0011;
            end
            exp = model(model_on, 1'b1, eff_a, k);
            got = {clk_en_o, arst_no, dom_on_o, busy_o, done_o, cmd_ready};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL b2b_first k=%0d: got=%b exp=%b", k, got, exp);
            end
        end
        model_on = model_on | eff_a;
        eff_b = eff_of(model_on, 1'b0, 4'b0011);
        tb = done_cycle(eff_b);
        for (int k = 1; k <= tb + 1; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            exp = model(model_on, 1'b0, eff_b, k);
            got = {clk_en_o, arst_no, dom_on_o, busy_o, done_o, cmd_ready};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL b2b_second k=%0d: got=%b exp=%b", k, got, exp);
            end
        end
        model_on = model_on & ~eff_b;
    endtask

    task automatic test_random();
        logic [3*ND+2:0] got, exp;
        logic [ND-1:0] eff, mask;
        logic on;
        int t;
        for (int it = 0; it < 10; it++) begin
            on   = 1'($urandom_range(0, 1));
            mask = ND'($urandom_range(0, (1 << ND) - 1));
            cmd_on = on; cmd_mask = mask; cmd_valid = 1'b1;
            eff = eff_of(model_on, on, mask);
            t = done_cycle(eff);
            for (int k = 1; k <= t + 1; k++) begin
                @(negedge clk);
                if (k == 1) cmd_valid = 1'b0;
                exp = model(model_on, on, eff, k);
                got = {clk_en_o, arst_no, dom_on_o, busy_o, done_o, cmd_ready};
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random it=%0d on=%0b mask=%b k=%0d: got=%b exp=%b",
                             it, on, mask, k, got, exp);
                end
            end
            model_on = on ? (model_on | eff) : (model_on & ~eff);
        end
    endtask

    initial begin
        clk       = 1'b0;
        arst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_on    = 1'b0;
        cmd_mask  = '0;
        model_on  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_power_up();
        test_power_down();
        test_noop();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
